pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline (F/D/E/M/RB).

---
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for the F/D/E/M/RB pipeline.
// Detects load-use hazards, applies branch redirect flushes, and sequences
// multi-cycle data-memory accesses in M. A memory access that runs too long
// is latched as a sticky fault. A saturating counter records the number of
// cycles in which the PC was held.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic             rs1_used_D,
    input  logic             rs2_used_D,
    input  logic [4:0]       rd_waddr_E,
    input  logic             rd_wen_E,
    input  logic             mem_read_E,
    input  logic             branch_taken_E,
    input  logic             mem_req_M,
    input  logic             dmem_ready,
    output logic             dmem_valid,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             bubble_RB,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [15:0]      TIMEOUT_LIM = 16'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        mem_stall;
    logic        load_use;

    // Load-use hazard: a load in E writes a register that the D instruction reads.
    // Writes to x0 are architecturally discarded, so they never create a hazard.
    always_comb begin
        load_use = 1'b0;
        if (mem_read_E && rd_wen_E && (rd_waddr_E != 5'd0)) begin
            load_use = (rs1_used_D && (rs1_addr_D == rd_waddr_E)) ||
                       (rs2_used_D && (rs2_addr_D == rd_waddr_E));
        end
    end

    // Memory stall is active whenever the access in M has not completed this cycle.
    always_comb begin
        unique case (state)
            RUN:      mem_stall = mem_req_M && !dmem_ready;
            MEM_WAIT: mem_stall = !dmem_ready;
            default:  mem_stall = 1'b0;
        endcase
    end

    // Control outputs, in priority order: fault, memory stall, redirect, load-use.
    // A redirect seen under a memory stall is not lost: E is frozen, so
    // branch_taken_E is still present in the release cycle and flushes then.
    always_comb begin
        dmem_valid = 1'b0;
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        stall_E    = 1'b0;
        stall_M    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        bubble_RB  = 1'b0;
        if (state == FAULT) begin
            stall_F   = 1'b1;
            stall_D   = 1'b1;
            stall_E   = 1'b1;
            stall_M   = 1'b1;
            bubble_RB = 1'b1;
        end else begin
            dmem_valid = (state == MEM_WAIT) ? 1'b1 : mem_req_M;
            if (mem_stall) begin
                stall_F   = 1'b1;
                stall_D   = 1'b1;
                stall_E   = 1'b1;
                stall_M   = 1'b1;
                bubble_RB = 1'b1;
            end else if (branch_taken_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    // Memory access sequencer with timeout; FAULT is left only through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_req_M && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TIMEOUT_LIM) begin
                        state     <= FAULT;
                        mem_fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_F && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized traffic, every
// output compared against a cycle-level behavioural model of the scheduler.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TMO  = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = 15;

    logic          clk;
    logic          rst;
    logic [4:0]    rs1_addr_D, rs2_addr_D, rd_waddr_E;
    logic          rs1_used_D, rs2_used_D, rd_wen_E, mem_read_E;
    logic          branch_taken_E, mem_req_M, dmem_ready;
    logic          dmem_valid, stall_F, stall_D, stall_E, stall_M;
    logic          flush_D, flush_E, bubble_RB, mem_fault;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .rd_waddr_E(rd_waddr_E), .rd_wen_E(rd_wen_E),
        .mem_read_E(mem_read_E), .branch_taken_E(branch_taken_E),
        .mem_req_M(mem_req_M), .dmem_ready(dmem_ready),
        .dmem_valid(dmem_valid), .stall_F(stall_F), .stall_D(stall_D),
        .stall_E(stall_E), .stall_M(stall_M), .flush_D(flush_D),
        .flush_E(flush_E), .bubble_RB(bubble_RB), .mem_fault(mem_fault),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: is an access outstanding, has it timed out, how many cycles it
    // has waited so far, and the number of PC-hold cycles seen.
    bit          m_waiting;
    bit          m_faulted;
    int unsigned m_waited;
    int unsigned m_holds;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_waiting = 0;
        m_faulted = 0;
        m_waited  = 0;
        m_holds   = 0;
    endtask

    // Compare all outputs against the model for the inputs now applied,
    // then (if adv) advance the model by the upcoming clock edge.
    task automatic compare_and_advance(input bit adv);
        bit hz, busy, e_dv, e_hold_pc, e_hold_de, e_flD, e_flE, e_bub;
        hz = mem_read_E && rd_wen_E && (rd_waddr_E != 0) &&
             ((rs1_used_D && rs1_addr_D == rd_waddr_E) ||
              (rs2_used_D && rs2_addr_D == rd_waddr_E));
        busy = m_faulted || (!dmem_ready && (m_waiting || mem_req_M));
        e_dv = !m_faulted && (m_waiting || mem_req_M);
        e_hold_pc = busy || (!branch_taken_E && hz);
        e_hold_de = busy;
        e_bub     = busy;
        e_flD     = !busy && branch_taken_E;
        e_flE     = !busy && (branch_taken_E || hz);

        check("dmem_valid", 32'(dmem_valid), 32'(e_dv));
        check("stall_F",    32'(stall_F),    32'(e_hold_pc));
        check("stall_D",    32'(stall_D),    32'(e_hold_pc));
        check("stall_E",    32'(stall_E),    32'(e_hold_de));
        check("stall_M",    32'(stall_M),    32'(e_hold_de));
        check("flush_D",    32'(flush_D),    32'(e_flD));
        check("flush_E",    32'(flush_E),    32'(e_flE));
        check("bubble_RB",  32'(bubble_RB),  32'(e_bub));
        check("mem_fault",  32'(mem_fault),  32'(m_faulted));
        check("stall_cnt",  32'(stall_cnt),  m_holds);

        if (adv) begin
            if (e_hold_pc && m_holds < CMAX) m_holds++;
            if (!m_faulted) begin
                if (m_waiting) begin
                    if (dmem_ready) begin
                        m_waiting = 0;
                    end else if (m_waited == TMO) begin
                        m_waiting = 0;
                        m_faulted = 1;
                    end else begin
                        m_waited++;
                    end
                end else if (mem_req_M && !dmem_ready) begin
                    m_waiting = 1;
                    m_waited  = 1;
                end
            end
        end
    endtask

    task automatic set_in(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic wen,
                          input logic ld, input logic br, input logic req, input logic rdy);
        rs1_addr_D = r1; rs1_used_D = u1; rs2_addr_D = r2; rs2_used_D = u2;
        rd_waddr_E = rd; rd_wen_E = wen; mem_read_E = ld;
        branch_taken_E = br; mem_req_M = req; dmem_ready = rdy;
    endtask

    task automatic idle_in();
        set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock cycle with the given inputs: apply after the falling edge,
    // check mid-cycle, and let the rising edge commit.
    task automatic step(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic br, input logic req, input logic rdy);
        @(negedge clk);
        set_in(r1, u1, r2, u2, rd, wen, ld, br, req, rdy);
        #1;
        compare_and_advance(1'b1);
    endtask

    task automatic mem_step(input logic br, input logic rdy);
        step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, br, 1'b1, rdy);
    endtask

    // Asynchronous reset pulse inside a cycle, well clear of the rising edge.
    task automatic async_reset_idle();
        @(negedge clk);
        idle_in();
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        compare_and_advance(1'b0);
        check("rst_all_low", 32'({dmem_valid, stall_F, stall_D, stall_E, stall_M,
                                  flush_D, flush_E, bubble_RB, mem_fault}), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        model_reset();
        #12;
        rst = 1'b0;

        // Reset state with idle inputs.
        step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_cnt", 32'(stall_cnt), 32'd0);

        // lw x5 in E, add x6,x5,x1 in D: one-cycle bubble.
        step(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_stall_F", 32'(stall_F), 32'd1);
        step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        // Hazard via rs2 only; rs1 matching but unused must not stall.
        step(5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // x0 destination: no hazard.
        step(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("x0_no_stall", 32'(stall_F), 32'd0);
        // Redirect overrides load-use.
        step(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("br_flush_D", 32'(flush_D), 32'd1);

        // Zero-wait access, then a 3-cycle wait with a held redirect.
        mem_step(1'b0, 1'b1);
        mem_step(1'b1, 1'b0);
        mem_step(1'b1, 1'b0);
        mem_step(1'b1, 1'b0);
        check("wait_no_flush", 32'(flush_D), 32'd0);
        mem_step(1'b1, 1'b1);
        check("release_flush", 32'(flush_E), 32'd1);
        step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("back_to_run", 32'(dmem_valid), 32'd0);

        // Timeout: memory never ready -> sticky fault, then saturation.
        for (int i = 0; i < 7; i++) mem_step(1'b0, 1'b0);
        check("fault_set", 32'(mem_fault), 32'd1);
        check("fault_no_valid", 32'(dmem_valid), 32'd0);
        for (int i = 0; i < 20; i++) mem_step(1'b1, 1'b1);
        check("cnt_saturated", 32'(stall_cnt), 32'(CMAX));
        async_reset_idle();
        check("rst_cnt", 32'(stall_cnt), 32'd0);

        // Asynchronous reset in the middle of a wait.
        mem_step(1'b0, 1'b0);
        mem_step(1'b0, 1'b0);
        async_reset_idle();
        step(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomized traffic with small register numbers to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                async_reset_idle();
            end else begin
                step(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                     1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
